// File: rtl/instruction_fetcher_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetcher_pkg
// Description : Shared types and constants for the instruction fetch stage.
//               Provides the word type, boolean constants, the I-cache address
//               slicing constants and the fetch FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetcher_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t ZERO_WORD = '0;
  localparam logic  TRUE      = 1'b1;
  localparam logic  FALSE     = 1'b0;

  // The cache index starts just above the byte-in-word offset.
  localparam int ICACHE_IDX_LSB   = 2;
  localparam int ICACHE_IDX_W_DEF = 8;

  typedef enum logic [1:0] {
    FETCH_IDLE     = 2'd0,
    FETCH_WAIT_MEM = 2'd1,
    FETCH_DISCARD  = 2'd2
  } fetch_state_t;

  // Tag width left over once the index and word offset are removed.
  function automatic int icache_tag_w(input int idx_w);
    return WORD_W - idx_w - ICACHE_IDX_LSB;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_fetcher_if.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetcher_if
// Description : Bundle of the fetch stage's handshakes: decoder issue path,
//               ROB redirect, and memory-controller word fetch.
// Ports       : modport master - the fetch stage (drives mc_* requests and
//                                 dec_* issue outputs)
//               modport slave  - the surrounding core (drives stall, flush,
//                                 and memory responses)
// Revision    : 1.0 - initial release
// ============================================================================
interface instruction_fetcher_if;
  import instruction_fetcher_pkg::*;

  logic  dec_stall_in;
  logic  rob_flush_in;
  word_t rob_target_pc_in;
  logic  mc_req_out;
  word_t mc_addr_out;
  logic  mc_valid_in;
  word_t mc_data_in;
  logic  dec_issue_signal_out;
  word_t dec_inst_out;
  word_t dec_pc_out;

  modport master (
    input  dec_stall_in, rob_flush_in, rob_target_pc_in, mc_valid_in, mc_data_in,
    output mc_req_out, mc_addr_out, dec_issue_signal_out, dec_inst_out, dec_pc_out
  );

  modport slave (
    output dec_stall_in, rob_flush_in, rob_target_pc_in, mc_valid_in, mc_data_in,
    input  mc_req_out, mc_addr_out, dec_issue_signal_out, dec_inst_out, dec_pc_out
  );

endinterface
`default_nettype wire

// File: rtl/instruction_fetcher_icache_direct.sv
`default_nettype none
// ============================================================================
// Module      : icache_direct
// Description : Direct-mapped instruction cache, one 32-bit word per line.
//               Combinational lookup, single synchronous write port, valid
//               bits cleared synchronously on rst.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               i_rd_idx/tag  - lookup index and tag
//               o_hit         - line valid and tag matches
//               o_rd_data     - word stored in the indexed line
//               i_wr_en       - write strobe
//               i_wr_idx/tag  - line to fill
//               i_wr_data     - word to store
// Revision    : 1.0 - initial release
// ============================================================================
module icache_direct
  import instruction_fetcher_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W_DEF,
  parameter int TAG_W = WORD_W - ICACHE_IDX_W_DEF - ICACHE_IDX_LSB
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic [IDX_W-1:0] i_rd_idx,
  input  wire logic [TAG_W-1:0] i_rd_tag,
  output logic                  o_hit,
  output word_t                 o_rd_data,
  input  wire logic             i_wr_en,
  input  wire logic [IDX_W-1:0] i_wr_idx,
  input  wire logic [TAG_W-1:0] i_wr_tag,
  input  wire word_t            i_wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0] r_valid;
  logic [TAG_W-1:0] r_tag  [LINES];
  word_t            r_data [LINES];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[i_wr_idx] <= TRUE;
    end
  end

  // Tag/data need no reset: they are only trusted behind a valid bit.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_data;
    end
  end

  assign o_hit     = r_valid[i_rd_idx] && (r_tag[i_rd_idx] == i_rd_tag);
  assign o_rd_data = r_data[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetcher
// Description : Fetch stage. Holds the PC and a direct-mapped I-cache, fills
//               misses through the memory controller and issues one
//               instruction per cycle to the decoder. Predicts not-taken
//               (pc+4); the ROB redirects on flush.
// Ports       : clk, rst - clock, synchronous active-high reset
//               rdy      - global enable; low freezes all state
//               bus      - instruction_fetcher_if.master (decoder issue,
//                          ROB redirect, memory-controller fetch)
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetcher
  import instruction_fetcher_pkg::*;
#(
  parameter int    ICACHE_IDX_W = ICACHE_IDX_W_DEF,
  parameter word_t RESET_PC     = 32'h0
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               rdy,
  instruction_fetcher_if.master   bus
);

  localparam int TAG_W = icache_tag_w(ICACHE_IDX_W);

  fetch_state_t r_state, w_state_nxt;
  word_t        r_pc, w_pc_nxt;
  logic         r_mc_req, w_mc_req_nxt;
  word_t        r_mc_addr, w_mc_addr_nxt;
  logic         r_issue, w_issue_nxt;
  word_t        r_inst, w_inst_nxt;
  word_t        r_pc_out, w_pc_out_nxt;
  logic         w_fill;
  logic         w_hit;
  word_t        w_hit_data;

  // Lookup always follows the live PC; fills use the latched request
  // address because the PC may already have been redirected.
  icache_direct #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk       (clk),
    .rst       (rst),
    .i_rd_idx  (r_pc[ICACHE_IDX_W+ICACHE_IDX_LSB-1:ICACHE_IDX_LSB]),
    .i_rd_tag  (r_pc[WORD_W-1:ICACHE_IDX_W+ICACHE_IDX_LSB]),
    .o_hit     (w_hit),
    .o_rd_data (w_hit_data),
    .i_wr_en   (w_fill && rdy),
    .i_wr_idx  (r_mc_addr[ICACHE_IDX_W+ICACHE_IDX_LSB-1:ICACHE_IDX_LSB]),
    .i_wr_tag  (r_mc_addr[WORD_W-1:ICACHE_IDX_W+ICACHE_IDX_LSB]),
    .i_wr_data (bus.mc_data_in)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= FETCH_IDLE;
      r_pc      <= RESET_PC;
      r_mc_req  <= FALSE;
      r_mc_addr <= ZERO_WORD;
      r_issue   <= FALSE;
      r_inst    <= ZERO_WORD;
      r_pc_out  <= ZERO_WORD;
    end else if (rdy) begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_mc_req  <= w_mc_req_nxt;
      r_mc_addr <= w_mc_addr_nxt;
      r_issue   <= w_issue_nxt;
      r_inst    <= w_inst_nxt;
      r_pc_out  <= w_pc_out_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_mc_req_nxt  = r_mc_req;
    w_mc_addr_nxt = r_mc_addr;
    w_issue_nxt   = FALSE;
    w_inst_nxt    = r_inst;
    w_pc_out_nxt  = r_pc_out;
    w_fill        = FALSE;

    case (r_state)
      FETCH_IDLE: begin
        if (bus.rob_flush_in) begin
          w_pc_nxt = bus.rob_target_pc_in;
        end else if (bus.dec_stall_in) begin
          // Hold: neither issue nor start a fill while the back end is full.
        end else if (w_hit) begin
          w_issue_nxt  = TRUE;
          w_inst_nxt   = w_hit_data;
          w_pc_out_nxt = r_pc;
          w_pc_nxt     = r_pc + 32'd4;
        end else begin
          w_mc_req_nxt  = TRUE;
          w_mc_addr_nxt = {r_pc[WORD_W-1:ICACHE_IDX_LSB], 2'b00};
          w_state_nxt   = FETCH_WAIT_MEM;
        end
      end

      FETCH_WAIT_MEM: begin
        if (bus.mc_valid_in) begin
          w_fill       = TRUE;
          w_mc_req_nxt = FALSE;
          w_state_nxt  = FETCH_IDLE;
        end else if (bus.rob_flush_in) begin
          // Controller cannot abort; keep the request up and drop its result.
          w_state_nxt = FETCH_DISCARD;
        end
        if (bus.rob_flush_in) begin
          w_pc_nxt = bus.rob_target_pc_in;
        end
      end

      FETCH_DISCARD: begin
        if (bus.rob_flush_in) begin
          w_pc_nxt = bus.rob_target_pc_in;
        end
        // The returned word still belongs to r_mc_addr, so it is cached.
        if (bus.mc_valid_in) begin
          w_fill       = TRUE;
          w_mc_req_nxt = FALSE;
          w_state_nxt  = FETCH_IDLE;
        end
      end

      default: begin
        w_state_nxt = FETCH_IDLE;
      end
    endcase
  end

  assign bus.mc_req_out           = r_mc_req;
  assign bus.mc_addr_out          = r_mc_addr;
  // The held pulse is masked while frozen and delivered once rdy returns.
  assign bus.dec_issue_signal_out = r_issue && rdy;
  assign bus.dec_inst_out         = r_inst;
  assign bus.dec_pc_out           = r_pc_out;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetcher
// Description : Self-checking bench for instruction_fetcher: directed vectors
//               for hit streaming/stall/flush plus hand sequences for cold
//               start, flush during miss, conflict eviction, rdy/reset and
//               PC wrap.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetcher;
  import instruction_fetcher_pkg::*;

  localparam int LAT = 4;

  logic  clk;
  logic  rst;
  logic  rdy;
  int    cyc = 0;
  int    n_tests = 0;
  int    n_fail = 0;

  logic  resp_valid = 1'b0;
  word_t resp_data = '0;
  logic  force_valid = 1'b0;
  word_t force_data = '0;
  logic  mem_en = 1'b1;
  int    lat_cnt = 0;
  int    valid_cyc = 0;
  int    req_cnt = 0;
  logic  req_prev = 1'b0;

  word_t got_pc, got_inst, last_req_addr;
  int    got_cyc;
  bit    addr_unstable;

  instruction_fetcher_if u_if();

  assign u_if.mc_valid_in = resp_valid | force_valid;
  assign u_if.mc_data_in  = force_valid ? force_data : resp_data;

  instruction_fetcher #(
    .ICACHE_IDX_W (8),
    .RESET_PC     (32'h0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic word_t mem_word(input word_t a);
    return 32'h00000513 + (a << 8);
  endfunction

  // Memory controller model: answers each request LAT enabled cycles later.
  always @(negedge clk) begin
    if (u_if.mc_req_out && !req_prev) req_cnt++;
    req_prev = u_if.mc_req_out;
    if (rst || !mem_en) begin
      lat_cnt = 0;
      resp_valid = 1'b0;
    end else if (resp_valid) begin
      resp_valid = 1'b0;
      lat_cnt = 0;
    end else if (u_if.mc_req_out && rdy) begin
      lat_cnt++;
      if (lat_cnt == LAT) begin
        resp_valid = 1'b1;
        resp_data  = mem_word(u_if.mc_addr_out);
        valid_cyc  = cyc;
      end
    end
  end

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_issue(input string name);
    bit    seen = 1'b0;
    bit    prev_req = 1'b0;
    word_t prev_addr = '0;
    last_req_addr = 32'hDEADBEEF;
    addr_unstable = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clk);
      if (u_if.mc_req_out) begin
        if (prev_req && u_if.mc_addr_out != prev_addr) addr_unstable = 1'b1;
        last_req_addr = u_if.mc_addr_out;
      end
      prev_req  = u_if.mc_req_out;
      prev_addr = u_if.mc_addr_out;
      if (u_if.dec_issue_signal_out) begin
        seen     = 1'b1;
        got_pc   = u_if.dec_pc_out;
        got_inst = u_if.dec_inst_out;
        got_cyc  = cyc;
      end
    end
    if (!seen) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s timeout: got no issue, expected an issue pulse", name);
    end
  endtask

  task automatic expect_issue(input string name, input word_t pc);
    wait_issue(name);
    chk({name, " pc"}, got_pc, pc);
    chk({name, " inst"}, got_inst, mem_word(pc));
  endtask

  // Redirect from IDLE: one flush cycle, then release stall and flush.
  task automatic go_to(input word_t tgt);
    u_if.dec_stall_in     = 1'b0;
    u_if.rob_flush_in     = 1'b1;
    u_if.rob_target_pc_in = tgt;
    @(negedge clk);
    u_if.rob_flush_in     = 1'b0;
  endtask

  typedef struct {
    logic  stall;
    logic  flush;
    word_t tgt;
    logic  exp_issue;
    word_t exp_pc;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int  r0;
    int  prev_cyc;
    bit  frozen_bad;

    vecs[0]  = '{1'b1, 1'b1, 32'h0, 1'b0, 32'hC};
    vecs[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h4};
    vecs[3]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h4};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h4};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h4};
    vecs[6]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8};
    vecs[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 32'hC};
    vecs[8]  = '{1'b0, 1'b1, 32'h4, 1'b0, 32'hC};
    vecs[9]  = '{1'b0, 1'b1, 32'h8, 1'b0, 32'hC};
    vecs[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 32'h8};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h8};

    rst = 1'b1;
    rdy = 1'b1;
    u_if.dec_stall_in     = 1'b0;
    u_if.rob_flush_in     = 1'b0;
    u_if.rob_target_pc_in = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset req", 32'(u_if.mc_req_out), 32'h0);
    chk("reset addr", u_if.mc_addr_out, 32'h0);
    chk("reset issue", 32'(u_if.dec_issue_signal_out), 32'h0);
    chk("reset inst", u_if.dec_inst_out, 32'h0);
    chk("reset pc", u_if.dec_pc_out, 32'h0);
    rst = 1'b0;

    // Cold start and preload of 0..12
    expect_issue("cold0", 32'h0);
    chk("cold0 inst value", got_inst, 32'h00000513);
    chk("cold0 req addr", last_req_addr, 32'h0);
    chk("cold0 addr stable", 32'(addr_unstable), 32'h0);
    chk("cold0 valid-to-issue", 32'(got_cyc - valid_cyc), 32'd2);
    expect_issue("cold4", 32'h4);
    chk("cold4 req addr", last_req_addr, 32'h4);
    expect_issue("cold8", 32'h8);
    expect_issue("cold12", 32'hC);
    u_if.dec_stall_in = 1'b1;

    // Hit streaming, stall, flush priority
    r0 = req_cnt;
    for (int i = 0; i < 12; i++) begin
      u_if.dec_stall_in     = vecs[i].stall;
      u_if.rob_flush_in     = vecs[i].flush;
      u_if.rob_target_pc_in = vecs[i].tgt;
      @(negedge clk);
      chk($sformatf("vec%0d issue", i), 32'(u_if.dec_issue_signal_out), 32'(vecs[i].exp_issue));
      chk($sformatf("vec%0d pc", i), u_if.dec_pc_out, vecs[i].exp_pc);
      chk($sformatf("vec%0d inst", i), u_if.dec_inst_out, mem_word(vecs[i].exp_pc));
    end
    u_if.rob_flush_in = 1'b0;
    @(negedge clk);
    chk("stream no mem req", 32'(req_cnt - r0), 32'd0);

    // Flush during miss
    r0 = req_cnt;
    go_to(32'h40);
    @(negedge clk);
    chk("miss40 req", 32'(u_if.mc_req_out), 32'h1);
    chk("miss40 addr", u_if.mc_addr_out, 32'h40);
    u_if.rob_flush_in     = 1'b1;
    u_if.rob_target_pc_in = 32'h100;
    @(negedge clk);
    u_if.rob_flush_in = 1'b0;
    expect_issue("after flush first", 32'h100);
    u_if.dec_stall_in = 1'b1;
    chk("after flush req addr", last_req_addr, 32'h100);
    chk("after flush req count", 32'(req_cnt - r0), 32'd2);
    r0 = req_cnt;
    go_to(32'h40);
    @(negedge clk);
    u_if.dec_stall_in = 1'b1;
    chk("line40 hit issue", 32'(u_if.dec_issue_signal_out), 32'h1);
    chk("line40 hit pc", u_if.dec_pc_out, 32'h40);
    @(negedge clk);
    chk("line40 no req", 32'(req_cnt - r0), 32'd0);

    // Conflict eviction
    r0 = req_cnt;
    go_to(32'h400);
    expect_issue("evict400", 32'h400);
    u_if.dec_stall_in = 1'b1;
    chk("evict400 req addr", last_req_addr, 32'h400);
    go_to(32'h0);
    expect_issue("refetch0", 32'h0);
    u_if.dec_stall_in = 1'b1;
    chk("refetch0 req addr", last_req_addr, 32'h0);
    chk("evict req count", 32'(req_cnt - r0), 32'd2);

    // rdy freeze in WAIT_MEM, then reset while waiting
    mem_en = 1'b0;
    go_to(32'h200);
    @(negedge clk);
    chk("wait200 req", 32'(u_if.mc_req_out), 32'h1);
    chk("wait200 addr", u_if.mc_addr_out, 32'h200);
    rdy = 1'b0;
    force_valid = 1'b1;
    force_data  = 32'h12345678;
    frozen_bad  = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (!u_if.mc_req_out || u_if.mc_addr_out != 32'h200 || u_if.dec_issue_signal_out)
        frozen_bad = 1'b1;
    end
    chk("rdy0 frozen", 32'(frozen_bad), 32'h0);
    rdy = 1'b1;
    force_valid = 1'b0;
    @(negedge clk);
    chk("rdy1 still waiting", 32'(u_if.mc_req_out), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    chk("rst req", 32'(u_if.mc_req_out), 32'h0);
    chk("rst addr", u_if.mc_addr_out, 32'h0);
    chk("rst issue", 32'(u_if.dec_issue_signal_out), 32'h0);
    chk("rst pc out", u_if.dec_pc_out, 32'h0);
    rst = 1'b0;
    mem_en = 1'b1;
    expect_issue("post-rst", 32'h0);
    chk("post-rst refill req", last_req_addr, 32'h0);
    u_if.dec_stall_in = 1'b1;

    // PC wrap
    go_to(32'hFFFFFFFC);
    expect_issue("wrap top", 32'hFFFFFFFC);
    prev_cyc = got_cyc;
    expect_issue("wrap zero", 32'h0);
    chk("wrap back-to-back", 32'(got_cyc - prev_cyc), 32'd1);
    chk("wrap no req", last_req_addr, 32'hDEADBEEF);
    u_if.dec_stall_in = 1'b1;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
